// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: shared types and default widths for the SPI RAM controller.
//   cmd_t   - 2-bit command carried in din[9:8]
//   state_t - read-path FSM state, also exported on the debug port
package spi_ram_pkg;

  localparam int DATA_W        = 8;
  localparam int CMD_W         = 2;
  localparam int WORD_W        = CMD_W + DATA_W;
  localparam int DEF_MEM_DEPTH = 256;
  localparam int DEF_ADDR_SIZE = 8;
  localparam int DEF_RD_LAT    = 1;
  localparam int LAT_CNT_W     = 3;   // holds RD_LAT up to 4

  typedef enum logic [CMD_W-1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_WAIT = 2'd1,
    TX_HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/spi_ram_ctrl_if.sv
// spi_ram_ctrl_if: link between the SPI slave and the RAM controller.
//   din[9:8]  command, din[7:0] payload (slave -> controller)
//   rx_valid  word-present level (slave -> controller)
//   dout      read data for MISO (controller -> slave)
//   tx_valid  dout valid (controller -> slave)
//   err       one-cycle pulse on a rejected command (controller -> slave)
//
// Handshake: there is no ready. rx_valid is a level that may stay high for
// many cycles; the controller takes exactly one word per low-to-high
// transition of rx_valid, sampling din on that cycle only. tx_valid, once
// raised, holds dout stable until the next accepted word, which drops both.
interface spi_ram_ctrl_if;
  import spi_ram_pkg::*;

  logic [WORD_W-1:0] din;
  logic              rx_valid;
  logic [DATA_W-1:0] dout;
  logic              tx_valid;
  logic              err;

  modport master (output din, rx_valid, input dout, tx_valid, err);
  modport slave  (input din, rx_valid, output dout, tx_valid, err);
endinterface

// File: rtl/sp_ram_core.sv
// sp_ram_core: single-port synchronous RAM, one access per cycle.
//   clk   clock
//   en    access enable
//   we    1 = write wdata to addr, 0 = read addr into rdata
//   addr  word address
//   wdata write data
//   rdata registered read data, valid the cycle after a read; holds
//         its value while no further read is issued
module sp_ram_core #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [7:0]           wdata,
  output logic [7:0]           rdata
);

  logic [7:0] mem_q [MEM_DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem_q[addr] <= wdata;
      else    rdata_q     <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: RAM back end of an SPI slave.
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   bus      spi_ram_ctrl_if.slave (din, rx_valid in; dout, tx_valid, err out)
//   state_o  current read-path FSM state (debug)
// Commands: 00 set write address, 01 write data, 10 set read address,
// 11 read data. Read data appears on dout/tx_valid RD_LAT cycles after the
// accepting edge of command 11. With AUTO_INC=1 the address used by a data
// command advances by one afterwards, wrapping modulo MEM_DEPTH.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int RD_LAT    = DEF_RD_LAT,
  parameter int AUTO_INC  = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_ram_ctrl_if.slave  bus,
  output state_t         state_o
);

  localparam logic [LAT_CNT_W-1:0] LAT = LAT_CNT_W'(RD_LAT);

  state_t                 state_q;
  logic                   rx_valid_q;   // rx_valid delayed one cycle
  logic [ADDR_SIZE-1:0]   wr_addr_q, rd_addr_q;
  logic                   wr_vld_q, rd_vld_q;
  logic [LAT_CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]      dout_q;
  logic                   tx_valid_q;
  logic                   err_q;

  logic                   accept;
  cmd_t                   cmd;
  logic [DATA_W-1:0]      payload;
  logic                   wr_ok, rd_ok, rejected;
  logic                   ram_en;
  logic [ADDR_SIZE-1:0]   ram_addr;
  logic [DATA_W-1:0]      ram_rdata;

  assign accept   = bus.rx_valid & ~rx_valid_q;
  assign cmd      = cmd_t'(bus.din[WORD_W-1:DATA_W]);
  assign payload  = bus.din[DATA_W-1:0];

  assign wr_ok    = accept && (cmd == CMD_WR_DATA) && wr_vld_q;
  assign rd_ok    = accept && (cmd == CMD_RD_DATA) && rd_vld_q;
  assign rejected = accept && (((cmd == CMD_WR_DATA) && !wr_vld_q) ||
                               ((cmd == CMD_RD_DATA) && !rd_vld_q));

  // The RAM is touched only on an accept edge, so a read and a write can
  // never collide, and rdata stays put for the whole READ_WAIT window.
  assign ram_en   = wr_ok | rd_ok;
  assign ram_addr = wr_ok ? wr_addr_q : rd_addr_q;

  sp_ram_core #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (wr_ok),
    .addr  (ram_addr),
    .wdata (payload),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rx_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      wr_vld_q   <= 1'b0;
      rd_vld_q   <= 1'b0;
      cnt_q      <= '0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rx_valid_q <= bus.rx_valid;
      err_q      <= rejected;
      if (accept) begin
        // Every accepted word, even a rejected one, retires the previous
        // read result and aborts any read still in flight.
        dout_q     <= '0;
        tx_valid_q <= 1'b0;
        case (cmd)
          CMD_WR_ADDR: begin
            wr_addr_q <= ADDR_SIZE'(payload);
            wr_vld_q  <= 1'b1;
          end
          CMD_WR_DATA: begin
            if (wr_vld_q && (AUTO_INC != 0)) wr_addr_q <= wr_addr_q + ADDR_SIZE'(1);
          end
          CMD_RD_ADDR: begin
            rd_addr_q <= ADDR_SIZE'(payload);
            rd_vld_q  <= 1'b1;
          end
          CMD_RD_DATA: begin
            if (rd_vld_q && (AUTO_INC != 0)) rd_addr_q <= rd_addr_q + ADDR_SIZE'(1);
          end
        endcase
        if (rd_ok) begin
          // The RAM registers its data on this edge, which is latency cycle 1.
          state_q <= READ_WAIT;
          cnt_q   <= LAT_CNT_W'(1);
        end else begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      end else begin
        case (state_q)
          READ_WAIT: begin
            if (cnt_q == LAT) begin
              dout_q     <= ram_rdata;
              tx_valid_q <= 1'b1;
              state_q    <= TX_HOLD;
              cnt_q      <= '0;
            end else begin
              cnt_q <= cnt_q + LAT_CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.dout     = dout_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.err      = err_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Testbench for spi_ram_ctrl. Two instances share clock and reset:
//   u_a : RD_LAT=1, AUTO_INC=0
//   u_b : RD_LAT=4, AUTO_INC=1
module tb_spi_ram_ctrl;
  import spi_ram_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t st_a, st_b;
  int     n_vec = 0;
  int     n_bad = 0;
  int     errc_a = 0;

  spi_ram_ctrl_if bus_a ();
  spi_ram_ctrl_if bus_b ();

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .RD_LAT(1), .AUTO_INC(0)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .state_o(st_a));
  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .RD_LAT(4), .AUTO_INC(1)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .state_o(st_b));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus_a.err === 1'b1) errc_a++;

  // ---------------- driver helpers ----------------
  function automatic logic tx_of(input bit sel);
    return sel ? bus_b.tx_valid : bus_a.tx_valid;
  endfunction
  function automatic logic [7:0] dout_of(input bit sel);
    return sel ? bus_b.dout : bus_a.dout;
  endfunction
  function automatic logic err_of(input bit sel);
    return sel ? bus_b.err : bus_a.err;
  endfunction
  function automatic state_t st_of(input bit sel);
    return sel ? st_b : st_a;
  endfunction

  // One rx_valid pulse; returns on the negedge just after the accept edge.
  task automatic send(input bit sel, input logic [9:0] w);
    @(negedge clk);
    if (sel) begin bus_b.din = w; bus_b.rx_valid = 1'b1; end
    else     begin bus_a.din = w; bus_a.rx_valid = 1'b1; end
    @(negedge clk);
    if (sel) bus_b.rx_valid = 1'b0;
    else     bus_a.rx_valid = 1'b0;
  endtask

  // Counts cycles from the accept edge until tx_valid, bounded at 12.
  task automatic wait_tx(input bit sel, output int lat, output logic [7:0] d);
    lat = 0;
    while (tx_of(sel) !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    d = dout_of(sel);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus_a.din = '0; bus_a.rx_valid = 1'b0;
    bus_b.din = '0; bus_b.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (bus_a.dout !== 8'h00) begin n_bad++; $display("FAIL reset_dout got=%h exp=00", bus_a.dout); end
    n_vec++; if (bus_a.tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tx got=%b exp=0", bus_a.tx_valid); end
    n_vec++; if (bus_a.err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", bus_a.err); end
    n_vec++; if (st_a !== IDLE) begin n_bad++; $display("FAIL reset_state_a got=%0d exp=%0d", st_a, IDLE); end
    n_vec++; if (bus_b.tx_valid !== 1'b0 || st_b !== IDLE) begin
      n_bad++; $display("FAIL reset_b got tx=%b st=%0d exp tx=0 st=0", bus_b.tx_valid, st_b); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat; logic [7:0] d; int e0;
    e0 = errc_a;
    send(0, 10'h03C);
    send(0, 10'h1A5);
    send(0, 10'h23C);
    send(0, 10'h300);
    n_vec++; if (bus_a.tx_valid !== 1'b0) begin n_bad++; $display("FAIL basic_tx_at_accept got=%b exp=0", bus_a.tx_valid); end
    wait_tx(0, lat, d);
    n_vec++; if (lat != 1) begin n_bad++; $display("FAIL basic_latency got=%0d exp=1", lat); end
    n_vec++; if (d !== 8'hA5) begin n_bad++; $display("FAIL basic_dout got=%h exp=a5", d); end
    n_vec++; if (st_a !== TX_HOLD) begin n_bad++; $display("FAIL basic_state got=%0d exp=%0d", st_a, TX_HOLD); end
    n_vec++; if (errc_a != e0) begin n_bad++; $display("FAIL basic_err_cycles got=%0d exp=0", errc_a - e0); end
  endtask

  task automatic level_write(input bit sel);
    send(sel, 10'h011);
    send(sel, 10'h15A);
    send(sel, 10'h010);
    @(negedge clk);
    if (sel) begin bus_b.din = 10'h177; bus_b.rx_valid = 1'b1; end
    else     begin bus_a.din = 10'h177; bus_a.rx_valid = 1'b1; end
    repeat (20) @(negedge clk);
    if (sel) bus_b.rx_valid = 1'b0;
    else     bus_a.rx_valid = 1'b0;
  endtask

  task automatic test_level_rx_valid();
    int lat; logic [7:0] d;
    // A: fixed addresses
    level_write(0);
    send(0, 10'h210); send(0, 10'h300);
    wait_tx(0, lat, d);
    n_vec++; if (d !== 8'h77 || lat != 1) begin n_bad++; $display("FAIL level_a_0x10 got=%h/%0d exp=77/1", d, lat); end
    send(0, 10'h211); send(0, 10'h300);
    wait_tx(0, lat, d);
    n_vec++; if (d !== 8'h5A) begin n_bad++; $display("FAIL level_a_0x11 got=%h exp=5a", d); end
    // B: a retriggered write would advance wr_addr and clobber 0x11
    level_write(1);
    send(1, 10'h210); send(1, 10'h300);
    wait_tx(1, lat, d);
    n_vec++; if (d !== 8'h77 || lat != 4) begin n_bad++; $display("FAIL level_b_0x10 got=%h/%0d exp=77/4", d, lat); end
    send(1, 10'h300);
    wait_tx(1, lat, d);
    n_vec++; if (d !== 8'h5A) begin n_bad++; $display("FAIL level_b_0x11 got=%h exp=5a", d); end
  endtask

  task automatic test_proto_err();
    int lat; logic [7:0] d;
    send(0, 10'h000);
    send(0, 10'h142);
    do_reset();
    send(0, 10'h300);
    n_vec++; if (bus_a.err !== 1'b1) begin n_bad++; $display("FAIL perr_rd_err got=%b exp=1", bus_a.err); end
    n_vec++; if (bus_a.tx_valid !== 1'b0) begin n_bad++; $display("FAIL perr_rd_tx got=%b exp=0", bus_a.tx_valid); end
    @(negedge clk);
    n_vec++; if (bus_a.err !== 1'b0) begin n_bad++; $display("FAIL perr_pulse_width got=%b exp=0", bus_a.err); end
    repeat (3) @(negedge clk);
    n_vec++; if (bus_a.tx_valid !== 1'b0 || st_a !== IDLE) begin
      n_bad++; $display("FAIL perr_rd_idle got tx=%b st=%0d exp tx=0 st=0", bus_a.tx_valid, st_a); end
    send(0, 10'h199);
    n_vec++; if (bus_a.err !== 1'b1) begin n_bad++; $display("FAIL perr_wr_err got=%b exp=1", bus_a.err); end
    send(0, 10'h200); send(0, 10'h300);
    n_vec++; if (bus_a.err !== 1'b0) begin n_bad++; $display("FAIL perr_valid_rd_err got=%b exp=0", bus_a.err); end
    wait_tx(0, lat, d);
    n_vec++; if (d !== 8'h42) begin n_bad++; $display("FAIL perr_mem_unchanged got=%h exp=42", d); end
  endtask

  task automatic test_auto_inc_wrap();
    int lat; logic [7:0] d;
    send(1, 10'h0FF);
    send(1, 10'h111);
    send(1, 10'h122);
    send(1, 10'h2FF);
    send(1, 10'h300);
    wait_tx(1, lat, d);
    n_vec++; if (lat != 4) begin n_bad++; $display("FAIL wrap_latency got=%0d exp=4", lat); end
    n_vec++; if (d !== 8'h11) begin n_bad++; $display("FAIL wrap_mem_ff got=%h exp=11", d); end
    send(1, 10'h300);
    wait_tx(1, lat, d);
    n_vec++; if (d !== 8'h22) begin n_bad++; $display("FAIL wrap_mem_00 got=%h exp=22", d); end
  endtask

  task automatic test_flush_hold();
    int lat; logic [7:0] d; int tx_seen; int stable;
    send(1, 10'h2FF);
    send(1, 10'h300);
    send(1, 10'h000);        // accepted two cycles into the 4-cycle wait
    tx_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus_b.tx_valid !== 1'b0) tx_seen++;
    end
    n_vec++; if (tx_seen != 0) begin n_bad++; $display("FAIL flush_no_tx got=%0d exp=0", tx_seen); end
    n_vec++; if (st_b !== IDLE) begin n_bad++; $display("FAIL flush_state got=%0d exp=%0d", st_b, IDLE); end
    // rd_addr moved past 0xFF on the aborted read, so this reads 0x00
    send(1, 10'h300);
    wait_tx(1, lat, d);
    n_vec++; if (d !== 8'h22 || lat != 4) begin n_bad++; $display("FAIL flush_next_read got=%h/%0d exp=22/4", d, lat); end
    stable = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus_b.tx_valid === 1'b1 && bus_b.dout === 8'h22) stable++;
    end
    n_vec++; if (stable != 6) begin n_bad++; $display("FAIL hold_stable got=%0d exp=6", stable); end
    send(1, 10'h205);
    n_vec++; if (bus_b.tx_valid !== 1'b0 || bus_b.dout !== 8'h00) begin
      n_bad++; $display("FAIL hold_clear got tx=%b dout=%h exp tx=0 dout=00", bus_b.tx_valid, bus_b.dout); end
  endtask

  task automatic test_midread_reset();
    // u_a is still holding 0x42 from the protocol-error test
    n_vec++; if (bus_a.tx_valid !== 1'b1 || bus_a.dout !== 8'h42) begin
      n_bad++; $display("FAIL mrst_pre_hold got tx=%b dout=%h exp tx=1 dout=42", bus_a.tx_valid, bus_a.dout); end
    send(1, 10'h300);
    n_vec++; if (st_b !== READ_WAIT) begin n_bad++; $display("FAIL mrst_in_wait got=%0d exp=%0d", st_b, READ_WAIT); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (st_b !== IDLE || bus_b.tx_valid !== 1'b0) begin
      n_bad++; $display("FAIL mrst_b_async got st=%0d tx=%b exp st=0 tx=0", st_b, bus_b.tx_valid); end
    n_vec++; if (bus_a.tx_valid !== 1'b0 || bus_a.dout !== 8'h00) begin
      n_bad++; $display("FAIL mrst_a_async got tx=%b dout=%h exp tx=0 dout=00", bus_a.tx_valid, bus_a.dout); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_vec++; if (bus_b.tx_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_dropped got=%b exp=0", bus_b.tx_valid); end
    send(1, 10'h300);
    n_vec++; if (bus_b.err !== 1'b1 || bus_b.tx_valid !== 1'b0) begin
      n_bad++; $display("FAIL mrst_rdvld_cleared got err=%b tx=%b exp err=1 tx=0", bus_b.err, bus_b.tx_valid); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_level_rx_valid();
    test_proto_err();
    test_auto_inc_wrap();
    test_flush_hold();
    test_midread_reset();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
- Downstream stage of the SPI slave.
- Consumes the slave's 10-bit received word (2-bit command, 8-bit payload) and its rx_valid.
- Owns a single-port synchronous RAM and returns read data to the slave on tx_data/tx_valid, which the slave serialises onto MISO.
- Adds rx_valid edge detection, address-valid tracking, configurable read latency, optional address auto-increment and a protocol-error pulse.

Parameters:
- MEM_DEPTH, 256, number of 8-bit words.
- ADDR_SIZE, 8, address width; MEM_DEPTH must equal 2**ADDR_SIZE.
- RD_LAT, 1, cycles from read-command acceptance to tx_valid; legal values 1..4.
- AUTO_INC, 0, when 1, wr_addr/rd_addr increment after each data write/read, wrapping modulo MEM_DEPTH.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- din  in  10  received word from SPI slave; [9:8] command, [7:0] payload.
- rx_valid  in  1  level from slave; may stay high for many cycles per word.
- dout  out  8  read data to slave tx_data.
- tx_valid  out  1  dout is valid; held until next accepted command.
- err  out  1  one-cycle pulse on a rejected command.

Behaviour:
- Reset is asynchronous and active-low (rst_n) on the single clock clk. rst_n low clears dout=0, tx_valid=0, err=0, wr_addr=0, rd_addr=0, wr_vld=0, rd_vld=0, rx_valid_d=0, FSM=IDLE, latency counter=0.
- RAM contents are not reset; the bench must write before reading.
- Accept: a command is accepted only on the cycle where rx_valid=1 and rx_valid_d=0 (rising edge). rx_valid_d is rx_valid registered. Holding rx_valid high never re-triggers.
- din is sampled on the accept cycle only.
- Command 00 (write address): wr_addr<=din[7:0], wr_vld<=1.
- Command 01 (write data):
  - If wr_vld=1: mem[wr_addr]<=din[7:0] on the accept cycle's clock edge. If AUTO_INC, wr_addr<=wr_addr+1 (0xFF wraps to 0x00).
  - If wr_vld=0: no write, err=1 for one cycle.
- Command 10 (read address): rd_addr<=din[7:0], rd_vld<=1.
- Command 11 (read data):
  - If rd_vld=1: FSM enters READ_WAIT and issues the RAM read of rd_addr. If AUTO_INC, rd_addr<=rd_addr+1 after the address is captured for the read.
  - If rd_vld=0: err pulse, FSM unchanged.
- Any accepted command, including a rejected one, clears tx_valid and dout<=0 on the same edge.
- FSM:
  - IDLE -> READ_WAIT on an accepted valid 11.
  - READ_WAIT counts RD_LAT cycles. On the edge where count reaches RD_LAT: dout<=RAM data, tx_valid<=1, -> TX_HOLD.
  - TX_HOLD: tx_valid and dout stay stable until the next accepted command, then -> IDLE, or -> READ_WAIT if that command is a valid 11.
- Latency: tx_valid rises exactly RD_LAT cycles after the accept edge of command 11.
- Flush: an accepted command during READ_WAIT aborts the pending read. No tx_valid is produced for it, and the new command is processed normally.
- Single-port rule: RAM read and write never occur in the same cycle; commands are serialised by the edge detector.
- Write-then-read of the same address returns the new value.
- Address valid flags persist across commands and are cleared only by reset. Consecutive 11 commands without a new 10 re-read the same address, or the next address if AUTO_INC.
- rst_n asserted mid-read: pending read dropped, tx_valid=0 immediately (asynchronous).
- Bits din[9:8] are decoded exhaustively; there is no illegal command.

Decomposition:
- Package spi_ram_pkg holds:
  - the command enum (CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11);
  - the FSM state enum (IDLE, READ_WAIT, TX_HOLD);
  - default width constants.
- Sub-module sp_ram_core: single-port synchronous RAM, parameters MEM_DEPTH/ADDR_SIZE, ports clk, en, we, addr, wdata, rdata. rdata is registered with 1-cycle latency; the remaining RD_LAT-1 cycles come from the controller's counter.
- The controller holds the edge detector, decode, address registers and FSM.

Test Plan:
- Basic write/read: din=0x0_3C (cmd 00) pulse, 0x1_A5, 0x2_3C, 0x3_00 -> tx_valid rises RD_LAT cycles after the 4th accept with dout=0xA5; err never asserted.
- Level rx_valid: hold rx_valid high 20 cycles with din=0x1_77 after setting wr_addr=0x10 -> exactly one write. Readback of 0x10 gives 0x77, and 0x11 is unchanged.
- Protocol error after reset: cmd 11 with no prior cmd 10 -> err one-cycle pulse, tx_valid stays 0. Cmd 01 with no prior cmd 00 -> err, and mem is unchanged on later readback.
- Auto-increment wrap (AUTO_INC=1): wr_addr=0xFF, write 0x11 then 0x22 -> mem[0xFF]=0x11, mem[0x00]=0x22. rd_addr=0xFF with two reads -> dout 0x11 then 0x22.
- Flush and hold (RD_LAT=4): issue cmd 11, then cmd 00 two cycles later -> no tx_valid. A later valid read sets tx_valid high and holds it with dout stable until the next accept, then clears.
- Mid-read reset: pull rst_n low during READ_WAIT -> tx_valid=0, dout=0 immediately. After release, cmd 11 raises err (rd_vld cleared).
